dvp_capture_16bit: RTL and testbench

DVP camera capture front-end for the OV5640 video path. Runs in the camera pixel clock domain and samples the sensor's 8-bit DVP bus (vsync, href, data). Each byte pair is packed into one 16-bit RGB565 word. The block drives the write side of the frame FIFO: `fifo_data_in`, `fifo_data_in_en` and `fifo_data_vs`, with the FIFO reset taken from `fifo_data_vs`. It also discards settle frames after reset, gates capture per frame, clips oversize lines and frames, and flags geometry errors.

---
 rtl/dvp_capture_16bit.sv | 133 +++++++++++++
 tb/tb_dvp_capture_16bit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_16bit.sv
// OV5640 DVP capture: registers the 8-bit camera bus and packs byte pairs into RGB565 words.
// Drives the frame FIFO write side, and handles settle-frame skip, per-frame gating, clipping and geometry flags.
module dvp_capture_16bit #(
   parameter int H_ACTIVE    = 480,
   parameter int V_ACTIVE    = 272,
   parameter int SKIP_FRAMES = 10,
   parameter int BYTE_ORDER  = 0
) (
   input  logic        cmos_pclk,
   input  logic        rst,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_d,
   input  logic        cap_en,
   output logic [15:0] fifo_data_in,
   output logic        fifo_data_in_en,
   output logic        fifo_data_vs,
   output logic        frame_done,
   output logic        err_line,
   output logic        err_frame
);

   localparam logic [11:0] H_LIM    = 12'(H_ACTIVE);
   localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
   localparam logic [7:0]  SKIP_LIM = 8'(SKIP_FRAMES);

   typedef enum logic [1:0] {S_SKIP, S_WAIT, S_ACTIVE} state_t;

   state_t      state, state_nx;
   logic [7:0]  skip_cnt, skip_cnt_nx;
   logic        vs_r, href_r, vs_p, href_p;
   logic [7:0]  d_r, byte0;
   logic        phase;
   logic [11:0] pix_cnt;
   logic [10:0] line_cnt, line_cnt_inc, line_cnt_eof;
   logic        vs_rise, href_fall, active, pack, line_end;
   logic [15:0] word;

   assign vs_rise   = vs_r & ~vs_p;
   assign href_fall = href_p & ~href_r;
   assign active    = (state == S_ACTIVE);
   // href during the vsync pulse is not pixel data
   assign pack      = active & href_r & ~vs_r;
   assign line_end  = active & href_fall;
   assign word      = (BYTE_ORDER == 0) ? {byte0, d_r} : {d_r, byte0};

   assign line_cnt_inc = (line_cnt == 11'h7FF) ? line_cnt : line_cnt + 11'd1;
   // a line ending on the same cycle as vsync still counts toward the frame check
   assign line_cnt_eof = line_end ? line_cnt_inc : line_cnt;

   always_ff @(posedge cmos_pclk) begin
      if (!rst) begin
         state    <= S_SKIP;
         skip_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         skip_cnt <= skip_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      skip_cnt_nx = skip_cnt;
      if (vs_rise) begin
         case (state)
            S_SKIP: begin
               if (skip_cnt < SKIP_LIM) skip_cnt_nx = skip_cnt + 8'd1;
               else                     state_nx    = cap_en ? S_ACTIVE : S_WAIT;
            end
            S_WAIT, S_ACTIVE: state_nx = cap_en ? S_ACTIVE : S_WAIT;
            default: state_nx = S_SKIP;
         endcase
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (!rst) begin
         vs_r            <= 1'b0;
         href_r          <= 1'b0;
         d_r             <= 8'd0;
         vs_p            <= 1'b0;
         href_p          <= 1'b0;
         byte0           <= 8'd0;
         phase           <= 1'b0;
         pix_cnt         <= 12'd0;
         line_cnt        <= 11'd0;
         fifo_data_in    <= 16'd0;
         fifo_data_in_en <= 1'b0;
         fifo_data_vs    <= 1'b0;
         frame_done      <= 1'b0;
         err_line        <= 1'b0;
         err_frame       <= 1'b0;
      end else begin
         vs_r            <= cmos_vsync;
         href_r          <= cmos_href;
         d_r             <= cmos_d;
         vs_p            <= vs_r;
         href_p          <= href_r;
         fifo_data_vs    <= vs_r;
         fifo_data_in_en <= 1'b0;
         frame_done      <= 1'b0;
         phase           <= pack ? ~phase : 1'b0;

         if (pack && !phase) byte0 <= d_r;

         if (pack && phase) begin
            // clipped words still advance pix_cnt so the line length check sees them
            if (pix_cnt < H_LIM && line_cnt < V_LIM) begin
               fifo_data_in    <= word;
               fifo_data_in_en <= 1'b1;
            end
            if (pix_cnt != 12'hFFF) pix_cnt <= pix_cnt + 12'd1;
         end

         if (line_end) begin
            if (pix_cnt != H_LIM || phase) err_line <= 1'b1;
            line_cnt <= line_cnt_inc;
            pix_cnt  <= 12'd0;
         end

         if (vs_rise) begin
            if (active) begin
               frame_done <= 1'b1;
               if (line_cnt_eof != V_LIM) err_frame <= 1'b1;
            end
            line_cnt <= 11'd0;
            pix_cnt  <= 12'd0;
            phase    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dvp_capture_16bit.sv
// Bench for dvp_capture_16bit: two instances (skip 2 / byte order 0, skip 0 / byte order 1) driven by shared
// pins; a pin-level frame/line model predicts every strobe, word, pulse and flag with its cycle.
module tb_dvp_capture_16bit;
   localparam int H    = 4;
   localparam int V    = 2;
   localparam int MAXC = 8000;

   typedef struct {
      int          cyc;
      logic [15:0] v0;
      logic [15:0] v1;
      logic        en;
   } ev_t;

   logic        video_clk = 1'b0;
   logic        rst = 1'b0, cmos_vsync = 1'b0, cmos_href = 1'b0, cap_en = 1'b0;
   logic [7:0]  cmos_d = 8'd0;
   logic [15:0] data [2];
   logic        en [2], fvs [2], fd [2], el [2], ef [2];

   always #5 video_clk = ~video_clk;

   dvp_capture_16bit #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2), .BYTE_ORDER(0)) u_dut0 (
      .cmos_pclk(video_clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_d(cmos_d),
      .cap_en(cap_en), .fifo_data_in(data[0]), .fifo_data_in_en(en[0]), .fifo_data_vs(fvs[0]),
      .frame_done(fd[0]), .err_line(el[0]), .err_frame(ef[0]));

   dvp_capture_16bit #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0), .BYTE_ORDER(1)) u_dut1 (
      .cmos_pclk(video_clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_d(cmos_d),
      .cap_en(cap_en), .fifo_data_in(data[1]), .fifo_data_in_en(en[1]), .fifo_data_vs(fvs[1]),
      .frame_done(fd[1]), .err_line(el[1]), .err_frame(ef[1]));

   int cyc = 0;
   always @(posedge video_clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // model state
   ev_t  wr_q [2][$];
   ev_t  el_q [2][$];
   ev_t  ef_q [2][$];
   int   fd_q [2][$];
   bit   vs_h [MAXC];
   bit   rst_h [MAXC];
   int   sk [2];
   int   mode [2];      // 0 skipping, 1 waiting, 2 capturing
   int   skipped [2];
   int   lines [2];
   int   bcnt = 0;
   logic [7:0] pb = 8'd0;
   logic pv_vs = 1'b0, pv_h = 1'b0;

   function automatic ev_t mk(input int c, input logic [15:0] a, input logic [15:0] b, input logic e);
      ev_t r;
      r.cyc = c; r.v0 = a; r.v1 = b; r.en = e;
      return r;
   endfunction

   task automatic model_reset(input int k, input int n);
      while (wr_q[k].size() > 0 && wr_q[k][$].cyc > n) void'(wr_q[k].pop_back());
      while (el_q[k].size() > 0 && el_q[k][$].cyc > n) void'(el_q[k].pop_back());
      while (ef_q[k].size() > 0 && ef_q[k][$].cyc > n) void'(ef_q[k].pop_back());
      while (fd_q[k].size() > 0 && fd_q[k][$] > n) void'(fd_q[k].pop_back());
      wr_q[k].push_back(mk(n + 1, 16'h0, 16'h0, 1'b0));
      el_q[k].push_back(mk(n + 1, 16'h0, 16'h0, 1'b0));
      ef_q[k].push_back(mk(n + 1, 16'h0, 16'h0, 1'b0));
      mode[k] = 0; skipped[k] = 0; lines[k] = 0;
   endtask

   // Drive one cycle of pins and predict what the two instances must show two cycles later.
   task automatic step(input logic v, input logic h, input logic [7:0] dd, input logic r);
      int n;
      @(negedge video_clk);
      cmos_vsync = v; cmos_href = h; cmos_d = dd; rst = r;
      n = cyc;
      if (n < MAXC) begin vs_h[n] = v; rst_h[n] = r; end
      if (!r) begin
         for (int k = 0; k < 2; k++) model_reset(k, n);
         pv_vs = 1'b0; pv_h = 1'b0; bcnt = 0;
      end else begin
         if (pv_h && !h) begin
            for (int k = 0; k < 2; k++)
               if (mode[k] == 2) begin
                  if (bcnt / 2 != H || bcnt % 2 == 1) el_q[k].push_back(mk(n + 2, 16'h0, 16'h0, 1'b1));
                  lines[k]++;
               end
            bcnt = 0;
         end
         if (v && !pv_vs) begin
            for (int k = 0; k < 2; k++) begin
               if (mode[k] == 2) begin
                  fd_q[k].push_back(n + 2);
                  if (lines[k] != V) ef_q[k].push_back(mk(n + 2, 16'h0, 16'h0, 1'b1));
               end
               if (mode[k] == 0 && skipped[k] < sk[k]) skipped[k]++;
               else mode[k] = cap_en ? 2 : 1;
               lines[k] = 0;
            end
            bcnt = 0;
         end
         if (h && !v) begin
            if (bcnt % 2 == 1)
               for (int k = 0; k < 2; k++)
                  if (mode[k] == 2 && bcnt / 2 < H && lines[k] < V)
                     wr_q[k].push_back(mk(n + 2, {pb, dd}, {dd, pb}, 1'b1));
            pb = dd;
            bcnt++;
         end
         pv_vs = v; pv_h = h;
      end
   endtask

   // compare process
   int          cnt [2], fdc [2];
   logic [15:0] e_dat [2];
   logic        e_el [2], e_ef [2], prev_en [2];

   initial begin
      int   c;
      logic e_en, e_fd, e_vs;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; fdc[k] = 0; e_dat[k] = 16'h0; e_el[k] = 1'b0; e_ef[k] = 1'b0; prev_en[k] = 1'b0;
      end
      forever begin
         @(posedge video_clk);
         #1;
         c = cyc;
         if (c >= MAXC - 2) begin
            $display("FAIL timeout: cycle %0d reached limit %0d", c, MAXC);
            $fatal(1, "cycle budget exhausted");
         end
         for (int k = 0; k < 2; k++) begin
            e_en = 1'b0;
            while (wr_q[k].size() > 0 && wr_q[k][0].cyc <= c) begin
               if (wr_q[k][0].cyc == c) begin
                  e_en     = wr_q[k][0].en;
                  e_dat[k] = (k == 0) ? wr_q[k][0].v0 : wr_q[k][0].v1;
               end
               void'(wr_q[k].pop_front());
            end
            e_fd = 1'b0;
            while (fd_q[k].size() > 0 && fd_q[k][0] <= c) begin
               if (fd_q[k][0] == c) e_fd = 1'b1;
               void'(fd_q[k].pop_front());
            end
            while (el_q[k].size() > 0 && el_q[k][0].cyc <= c) begin
               e_el[k] = el_q[k][0].en; void'(el_q[k].pop_front());
            end
            while (ef_q[k].size() > 0 && ef_q[k][0].cyc <= c) begin
               e_ef[k] = ef_q[k][0].en; void'(ef_q[k].pop_front());
            end
            e_vs = (c >= 2) ? (vs_h[c-2] & rst_h[c-1] & rst_h[c-2]) : 1'b0;
            chk($sformatf("wr_en%0d", k), 32'(en[k]), 32'(e_en));
            chk($sformatf("data%0d", k), 32'(data[k]), 32'(e_dat[k]));
            chk($sformatf("frame_done%0d", k), 32'(fd[k]), 32'(e_fd));
            chk($sformatf("err_line%0d", k), 32'(el[k]), 32'(e_el[k]));
            chk($sformatf("err_frame%0d", k), 32'(ef[k]), 32'(e_ef[k]));
            chk($sformatf("fifo_vs%0d", k), 32'(fvs[k]), 32'(e_vs));
            chk($sformatf("en_b2b%0d", k), 32'(en[k] & prev_en[k]), 32'd0);
            prev_en[k] = en[k];
            if (en[k] === 1'b1) cnt[k]++;
            if (fd[k] === 1'b1) fdc[k]++;
         end
      end
   end

   // stimulus helpers
   int wb [2], fb [2], fw [2];

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 8'($urandom), 1'b1);
   endtask

   task automatic line(input int nb, input bit tail);
      logic [7:0] b;
      for (int j = 0; j < nb; j++) begin
         b = 8'($urandom);
         if (tail && j == nb - 2) b = 8'h12;
         if (tail && j == nb - 1) b = 8'h34;
         step(1'b0, 1'b1, b, 1'b1);
      end
      idle(3);
   endtask

   task automatic line_rst(input int nb, input int rp);
      for (int j = 0; j < nb; j++) step(1'b0, 1'b1, 8'($urandom), (j == rp) ? 1'b0 : 1'b1);
      idle(3);
   endtask

   // closes the previous frame's word count, then pulses vsync
   task automatic vsync_frame();
      idle(3);
      for (int k = 0; k < 2; k++) begin fw[k] = cnt[k] - wb[k]; wb[k] = cnt[k]; end
      repeat (3) step(1'b1, 1'b0, 8'($urandom), 1'b1);
      idle(3);
   endtask

   task automatic frame_chk(input string nm, input int e0, input int e1);
      chk({nm, "_words0"}, 32'(fw[0]), 32'(e0));
      chk({nm, "_words1"}, 32'(fw[1]), 32'(e1));
   endtask

   initial begin
      int nl, nb;
      sk[0] = 2; sk[1] = 0;
      for (int k = 0; k < 2; k++) begin
         mode[k] = 0; skipped[k] = 0; lines[k] = 0; wb[k] = 0; fb[k] = 0; fw[k] = 0;
      end
      repeat (4) step(1'b0, 1'b0, 8'hA5, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_data", 32'(data[k]), 32'd0);
         chk("reset_en", 32'(en[k]), 32'd0);
         chk("reset_flags", 32'({fvs[k], fd[k], el[k], ef[k]}), 32'd0);
      end
      idle(2);
      cap_en = 1'b1;

      // settle skip and byte packing: four clean 4x2 frames
      vsync_frame();
      line(8, 0); line(8, 1); vsync_frame();
      frame_chk("f1", 0, 8);
      chk("pack_order1", 32'(data[1]), 32'h3412);
      line(8, 0); line(8, 1); vsync_frame();
      frame_chk("f2", 0, 8);
      line(8, 0); line(8, 1); vsync_frame();
      frame_chk("f3", 8, 8);
      chk("pack_order0", 32'(data[0]), 32'h1234);
      line(8, 0); line(8, 1); vsync_frame();
      frame_chk("f4", 8, 8);
      chk("done_cnt0", 32'(fdc[0]), 32'd2);
      chk("done_cnt1", 32'(fdc[1]), 32'd4);
      chk("clean_flags", 32'({el[0], ef[0], el[1], ef[1]}), 32'd0);

      // short/odd line, then oversize line and frame
      line(7, 0);
      #1;
      chk("odd_line0", 32'(el[0]), 32'd1);
      chk("odd_line1", 32'(el[1]), 32'd1);
      line(8, 0); vsync_frame();
      frame_chk("f6", 7, 7);
      line(12, 0); line(8, 0); line(8, 0);
      cap_en = 1'b0;
      vsync_frame();
      frame_chk("f7", 8, 8);
      chk("long_frame0", 32'(ef[0]), 32'd1);
      chk("long_frame1", 32'(ef[1]), 32'd1);

      // enable gating
      line(8, 0); cap_en = 1'b1; line(8, 0); vsync_frame();
      frame_chk("f8", 0, 0);
      line(8, 0); cap_en = 1'b0; line(8, 0); vsync_frame();
      frame_chk("f9", 8, 8);
      line(8, 0); line(8, 0); cap_en = 1'b1; vsync_frame();
      frame_chk("f10", 0, 0);

      // reset in the middle of a line
      line(8, 0);
      wb[0] = cnt[0]; wb[1] = cnt[1];
      line_rst(8, 3);
      for (int k = 0; k < 2; k++) wb[k] = cnt[k];
      line(8, 0); vsync_frame();
      frame_chk("f11_after_rst", 0, 0);
      chk("rst_flags", 32'({el[0], ef[0], el[1], ef[1]}), 32'd0);
      line(8, 0); line(8, 0); vsync_frame();
      frame_chk("f12", 0, 8);

      // randomized frames
      for (int f = 0; f < 30; f++) begin
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++) begin
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12) : 8;
            if ($urandom_range(0, 14) == 0) line_rst(nb, $urandom_range(1, nb - 1));
            else line(nb, 0);
            if ($urandom_range(0, 4) == 0) cap_en = ~cap_en;
         end
         vsync_frame();
      end
      idle(6);
      chk("pending_wr0", 32'(wr_q[0].size()), 32'd0);
      chk("pending_wr1", 32'(wr_q[1].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
